iddr_delay_tune: RTL

//  Calibration controller for an input DDR capture path (IDDR behind a tap-programmable input delay).

---
 rtl/iddr_delay_tune.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/iddr_delay_tune.sv
// IDDR delay calibration: sweeps all taps against a training pattern, centres on the longest passing window.
// Latency NTAPS*(SETTLE_CYCLES+SAMPLE_COUNT+2)+2 cycles start->done; no backpressure, start ignored while busy.
module iddr_delay_tune #(
    parameter int WIDTH         = 5,
    parameter int TAP_W         = 5,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_COUNT  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] q1,
    input  logic [WIDTH-1:0] q2,
    input  logic [WIDTH-1:0] pattern_q1,
    input  logic [WIDTH-1:0] pattern_q2,
    output logic [TAP_W-1:0] delay_tap,
    output logic             delay_load,
    output logic             busy,
    output logic             done,
    output logic             locked,
    output logic             fail,
    output logic [TAP_W-1:0] win_start,
    output logic [TAP_W:0]   win_len
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_COUNT) ? SETTLE_CYCLES : SAMPLE_COUNT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TAP_W-1:0] TAP_ONE = {{(TAP_W-1){1'b0}}, 1'b1};
    localparam logic [TAP_W:0]   LEN_ONE = {{TAP_W{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_SAMPLE,
        S_EVAL,
        S_FINAL,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [TAP_W-1:0] tap;
    logic [TAP_W-1:0] tap_q;
    logic [TAP_W-1:0] run_start;
    logic [TAP_W-1:0] best_start;
    logic [TAP_W:0]   run_len;
    logic [TAP_W:0]   best_len;
    logic [TAP_W:0]   run_len_inc;
    logic [TAP_W-1:0] final_tap;
    logic             mismatch;
    logic             sample_bad;
    logic             settle_last;
    logic             sample_last;
    logic             last_tap;

    assign settle_last = (cnt == CNT_W'(SETTLE_CYCLES - 1));
    assign sample_last = (cnt == CNT_W'(SAMPLE_COUNT - 1));
    assign last_tap    = &tap;
    assign sample_bad  = (q1 != pattern_q1) || (q2 != pattern_q2);
    assign run_len_inc = run_len + LEN_ONE;

    // Centre of the window, biased toward its start when the length is even.
    assign final_tap = (best_len != '0) ? best_start + TAP_W'((best_len - LEN_ONE) >> 1) : '0;

    assign delay_load = (state == S_LOAD) || (state == S_FINAL);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign delay_tap  = (state == S_FINAL) ? final_tap : tap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_SETTLE;
            S_SETTLE: if (settle_last) state_nxt = S_SAMPLE;
            S_SAMPLE: if (sample_last) state_nxt = S_EVAL;
            S_EVAL:   state_nxt = last_tap ? S_FINAL : S_LOAD;
            S_FINAL:  state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            tap        <= '0;
            tap_q      <= '0;
            mismatch   <= 1'b0;
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
            locked     <= 1'b0;
            fail       <= 1'b0;
            win_start  <= '0;
            win_len    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt        <= '0;
                        tap        <= '0;
                        tap_q      <= '0;
                        mismatch   <= 1'b0;
                        run_start  <= '0;
                        run_len    <= '0;
                        best_start <= '0;
                        best_len   <= '0;
                        locked     <= 1'b0;
                        fail       <= 1'b0;
                        win_start  <= '0;
                        win_len    <= '0;
                    end
                end
                S_LOAD: begin
                    cnt <= '0;
                end
                S_SETTLE: begin
                    cnt <= settle_last ? '0 : cnt + CNT_ONE;
                end
                S_SAMPLE: begin
                    cnt <= sample_last ? '0 : cnt + CNT_ONE;
                    if (sample_bad) begin
                        mismatch <= 1'b1;
                    end
                end
                S_EVAL: begin
                    mismatch <= 1'b0;
                    if (!mismatch) begin
                        run_len <= run_len_inc;
                        if (run_len == '0) begin
                            run_start <= tap;
                        end
                        // Strict compare keeps the earliest window on ties.
                        if (run_len_inc > best_len) begin
                            best_len   <= run_len_inc;
                            best_start <= (run_len == '0) ? tap : run_start;
                        end
                    end else begin
                        run_len <= '0;
                    end
                    if (!last_tap) begin
                        tap   <= tap + TAP_ONE;
                        tap_q <= tap + TAP_ONE;
                    end
                end
                S_FINAL: begin
                    tap_q     <= final_tap;
                    win_start <= best_start;
                    win_len   <= best_len;
                    locked    <= (best_len != '0);
                    fail      <= (best_len == '0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
